// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - widths, FSM encoding and extrinsic arithmetic shared by the turbo iteration controller
package turbo_pkg;
    localparam int DW        = 10;
    localparam int SW        = 4;
    localparam int N_INFO    = 5;
    localparam int N_EXT     = 7;
    localparam int EXT_SHIFT = 1;
    localparam int TIMEOUT   = 16;
    localparam logic [3*N_INFO-1:0] PERM_DEFAULT = {3'd0, 3'd3, 3'd1, 3'd4, 3'd2};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    // -2^(DW-1) is excluded from the range: the Siso uses it as negative infinity
    localparam logic signed [DW+2:0] SAT_MAX = (DW+3)'(2**(DW-1) - 1);
    localparam logic signed [DW+2:0] SAT_MIN = -SAT_MAX;

    function automatic logic [DW-1:0] sat_dw(input logic signed [DW+2:0] v);
        if (v > SAT_MAX) return SAT_MAX[DW-1:0];
        if (v < SAT_MIN) return SAT_MIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] ext_calc(input logic [DW-1:0] llr,
                                               input logic [SW-1:0] sys,
                                               input logic [DW-1:0] ext_in);
        logic signed [DW+2:0] acc;
        acc = {{3{llr[DW-1]}}, llr}
            - {{(DW+2-SW){sys[SW-1]}}, sys, 1'b0}
            - {{2{ext_in[DW-1]}}, ext_in, 1'b0};
        acc = acc >>> EXT_SHIFT;
        return sat_dw(acc);
    endfunction
endpackage

// File: rtl/turbo_perm.sv
// rtl/turbo_perm.sv - combinational 7-lane interleaver/deinterleaver, tail lanes pass straight through
module turbo_perm
    import turbo_pkg::*;
#(
    parameter int                  WIDTH   = DW,
    parameter logic [3*N_INFO-1:0] PERM    = PERM_DEFAULT,
    parameter bit                  INVERSE = 1'b0
) (
    input  logic [N_EXT*WIDTH-1:0] src_data,
    output logic [N_EXT*WIDTH-1:0] dst_data
);
    // Lane g of the output is fed from lane src_lane(g); lane 0 sits in the MSBs
    function automatic int src_lane(input int g);
        if (g >= N_INFO) return g;
        if (!INVERSE) return int'(PERM[3*g +: 3]);
        for (int j = 0; j < N_INFO; j++) begin
            if (int'(PERM[3*j +: 3]) == g) return j;
        end
        return g;
    endfunction

    for (genvar g = 0; g < N_EXT; g++) begin : g_lane
        localparam int SRC = src_lane(g);
        assign dst_data[(N_EXT-1-g)*WIDTH +: WIDTH] = src_data[(N_EXT-1-SRC)*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/turbo_iter_ctrl.sv
// rtl/turbo_iter_ctrl.sv - time-shares one Siso between both constituent decoders and issues hard decisions
module turbo_iter_ctrl
    import turbo_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [3:0]            max_iter_i,
    input  logic [N_EXT*SW-1:0]   sys_i,
    input  logic [N_EXT*SW-1:0]   enc1_i,
    input  logic [N_EXT*SW-1:0]   enc2_i,
    output logic                  siso_read_en_o,
    output logic [N_EXT*SW-1:0]   siso_sys_o,
    output logic [N_EXT*SW-1:0]   siso_enc_o,
    output logic [N_EXT*DW-1:0]   siso_ext_o,
    input  logic [N_EXT*DW-1:0]   siso_llr_i,
    input  logic                  siso_finish_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [N_INFO-1:0]     bits_o,
    output logic                  error_o
);
    localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 2);

    state_t               state;
    logic [N_EXT*SW-1:0]  sys_q;
    logic [N_EXT*SW-1:0]  enc1_q;
    logic [N_EXT*SW-1:0]  enc2_q;
    logic [3:0]           max_iter_q;
    logic [3:0]           iter_q;
    logic                 half_q;
    logic [N_EXT*DW-1:0]  ext12_q;
    logic [N_EXT*DW-1:0]  ext21_q;
    logic [N_EXT*DW-1:0]  llr_q;
    logic [4:0]           tmo_cnt;

    logic [N_EXT*SW-1:0]  sys_int;
    logic [N_EXT*DW-1:0]  e_lane;
    logic [N_EXT*DW-1:0]  e_int;
    logic [N_EXT*DW-1:0]  e_deint;
    logic [N_EXT*DW-1:0]  llr_deint;
    logic [N_INFO-1:0]    dec;

    turbo_perm #(.WIDTH(SW), .INVERSE(1'b0)) u_sys_int   (.src_data(sys_q),  .dst_data(sys_int));
    turbo_perm #(.WIDTH(DW), .INVERSE(1'b0)) u_ext_int   (.src_data(e_lane), .dst_data(e_int));
    turbo_perm #(.WIDTH(DW), .INVERSE(1'b1)) u_ext_deint (.src_data(e_lane), .dst_data(e_deint));
    turbo_perm #(.WIDTH(DW), .INVERSE(1'b1)) u_llr_deint (.src_data(llr_q),  .dst_data(llr_deint));

    // New extrinsic is formed in the order the Siso just worked in; the perms map it to the other half
    for (genvar k = 0; k < N_EXT; k++) begin : g_ext
        assign e_lane[(N_EXT-1-k)*DW +: DW] = ext_calc(llr_q[(N_EXT-1-k)*DW +: DW],
                                                       siso_sys_o[(N_EXT-1-k)*SW +: SW],
                                                       siso_ext_o[(N_EXT-1-k)*DW +: DW]);
    end

    for (genvar i = 0; i < N_INFO; i++) begin : g_dec
        localparam int LSB = (N_EXT-1-i)*DW;
        assign dec[i] = !llr_deint[LSB+DW-1] && (llr_deint[LSB +: DW] != '0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= S_IDLE;
            sys_q          <= '0;
            enc1_q         <= '0;
            enc2_q         <= '0;
            max_iter_q     <= '0;
            iter_q         <= '0;
            half_q         <= 1'b0;
            ext12_q        <= '0;
            ext21_q        <= '0;
            llr_q          <= '0;
            tmo_cnt        <= '0;
            siso_read_en_o <= 1'b0;
            siso_sys_o     <= '0;
            siso_enc_o     <= '0;
            siso_ext_o     <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            bits_o         <= '0;
            error_o        <= 1'b0;
        end else begin
            siso_read_en_o <= 1'b0;
            done_o         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        sys_q      <= sys_i;
                        enc1_q     <= enc1_i;
                        enc2_q     <= enc2_i;
                        max_iter_q <= (max_iter_i == 4'd0) ? 4'd1 : max_iter_i;
                        ext12_q    <= '0;
                        ext21_q    <= '0;
                        iter_q     <= '0;
                        half_q     <= 1'b0;
                        error_o    <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    siso_sys_o     <= half_q ? sys_int : sys_q;
                    siso_enc_o     <= half_q ? enc2_q : enc1_q;
                    siso_ext_o     <= half_q ? ext12_q : ext21_q;
                    siso_read_en_o <= 1'b1;
                    state          <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (siso_finish_i) begin
                        llr_q <= siso_llr_i;
                        state <= S_UPDATE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error_o <= 1'b1;
                        bits_o  <= '0;
                        done_o  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 5'd1;
                    end
                end
                S_UPDATE: begin
                    half_q <= !half_q;
                    if (!half_q) begin
                        ext12_q <= e_int;
                        state   <= S_LOAD;
                    end else begin
                        ext21_q <= e_deint;
                        iter_q  <= iter_q + 4'd1;
                        if ({1'b0, iter_q} + 5'd1 == {1'b0, max_iter_q}) begin
                            bits_o <= dec;
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// tb/tb_turbo_iter_ctrl.sv - directed self-checking bench for turbo_iter_ctrl with a stub Siso model
module tb_turbo_iter_ctrl;
    localparam int M_ECHO   = 0;
    localparam int M_SCRIPT = 1;
    localparam int M_SILENT = 2;
    localparam logic [27:0] FRAME     = 28'h7977999;
    localparam logic [27:0] FRAME_INT = 28'h7997799;
    localparam logic [27:0] ENC1      = 28'h9797979;
    localparam logic [27:0] ENC2      = 28'h7799779;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic [3:0]  max_iter_i;
    logic [27:0] sys_i, enc1_i, enc2_i;
    logic        siso_read_en_o;
    logic [27:0] siso_sys_o, siso_enc_o;
    logic [69:0] siso_ext_o;
    logic [69:0] siso_llr_i;
    logic        siso_finish_i;
    logic        busy_o, done_o, error_o;
    logic [4:0]  bits_o;

    turbo_iter_ctrl dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .max_iter_i(max_iter_i),
        .sys_i(sys_i), .enc1_i(enc1_i), .enc2_i(enc2_i),
        .siso_read_en_o(siso_read_en_o), .siso_sys_o(siso_sys_o), .siso_enc_o(siso_enc_o),
        .siso_ext_o(siso_ext_o), .siso_llr_i(siso_llr_i), .siso_finish_i(siso_finish_i),
        .busy_o(busy_o), .done_o(done_o), .bits_o(bits_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int          n_reads, tmo_gap;
    logic        got_done, done_busy, after_busy, done_err;
    logic [4:0]  done_bits;
    logic [27:0] rd_sys [16];
    logic [27:0] rd_enc [16];
    logic [69:0] rd_ext [16];
    int          script [6];
    int          pat [7];

    typedef struct {
        int          mode;
        logic [3:0]  mi;
        logic [27:0] sys;
        int          reads;
        logic [4:0]  bits;
        logic        err;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [69:0] fill10(input int v);
        logic [69:0] r;
        for (int k = 0; k < 7; k++) r[k*10 +: 10] = v[9:0];
        return r;
    endfunction

    function automatic logic [69:0] pack10(input int v[7]);
        logic [69:0] r;
        int t;
        for (int k = 0; k < 7; k++) begin
            t = v[k];
            r[(6-k)*10 +: 10] = t[9:0];
        end
        return r;
    endfunction

    function automatic logic [69:0] model_llr(input int mode, input int idx, input logic [27:0] s);
        logic [69:0] r;
        logic [3:0]  l;
        r = '0;
        if (mode == M_ECHO) begin
            for (int k = 0; k < 7; k++) begin
                l = s[(6-k)*4 +: 4];
                r[(6-k)*10 +: 10] = {{4{l[3]}}, l, 2'b00};
            end
        end else if (idx < 6) begin
            r = fill10(script[idx]);
        end
        return r;
    endfunction

    // Stub Siso: finish pulses 5 cycles after each read_en unless silent
    task automatic run_decode(input int mode, input logic [3:0] mi, input logic [27:0] s,
                              input int poke_at, input int rst_at);
        int cd, first_rd;
        logic [69:0] mdl;
        n_reads = 0; got_done = 0; tmo_gap = -1; first_rd = -1; cd = 0; mdl = '0;
        after_busy = 1'bx; done_busy = 1'bx;
        max_iter_i = mi; sys_i = s; enc1_i = ENC1; enc2_i = ENC2; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            start_i = (c == poke_at);
            if (c == poke_at) begin
                sys_i = '0;
                max_iter_i = 4'd5;
            end
            siso_finish_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    siso_finish_i = 1'b1;
                    siso_llr_i = mdl;
                end
            end
            if (siso_read_en_o) begin
                if (n_reads < 16) begin
                    rd_sys[n_reads] = siso_sys_o;
                    rd_enc[n_reads] = siso_enc_o;
                    rd_ext[n_reads] = siso_ext_o;
                end
                if (first_rd < 0) first_rd = c;
                if (mode != M_SILENT) begin
                    cd = 5;
                    mdl = model_llr(mode, n_reads, siso_sys_o);
                end
                n_reads++;
                if (n_reads == rst_at) begin
                    reset_n_i = 1'b0;
                    siso_finish_i = 1'b0;
                    @(negedge clk);
                    chk("reset_mid_outputs",
                        {busy_o, done_o, siso_read_en_o, bits_o, error_o, siso_sys_o, siso_enc_o, siso_ext_o}, '0);
                    reset_n_i = 1'b1;
                    break;
                end
            end
            if (error_o && tmo_gap < 0) tmo_gap = c - first_rd;
            if (done_o) begin
                got_done = 1'b1;
                done_bits = bits_o;
                done_err = error_o;
                done_busy = busy_o;
            end
            @(negedge clk);
            if (got_done) begin
                after_busy = busy_o;
                break;
            end
        end
        start_i = 1'b0;
        siso_finish_i = 1'b0;
    endtask

    initial begin
        script = '{-512, 511, -512, 511, -512, 511};
        pat    = '{7, -7, -7, 7, 7, -7, -7};
        vecs[0] = '{M_ECHO,   4'd1, 28'h0000000, 2, 5'b00000, 1'b0};
        vecs[1] = '{M_ECHO,   4'd4, FRAME,       8, 5'b01101, 1'b0};
        vecs[2] = '{M_ECHO,   4'd0, FRAME,       2, 5'b01101, 1'b0};
        vecs[3] = '{M_SILENT, 4'd2, FRAME,       1, 5'b00000, 1'b1};
        vecs[4] = '{M_ECHO,   4'd2, 28'h9799777, 4, 5'b10010, 1'b0};
        vecs[5] = '{M_ECHO,   4'd1, 28'h1101100, 2, 5'b11011, 1'b0};

        reset_n_i = 1'b0; start_i = 1'b0; max_iter_i = '0; sys_i = '0; enc1_i = '0; enc2_i = '0;
        siso_llr_i = '0; siso_finish_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {busy_o, done_o, siso_read_en_o, bits_o, error_o, siso_sys_o, siso_enc_o, siso_ext_o}, '0);
        reset_n_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_decode(vecs[i].mode, vecs[i].mi, vecs[i].sys, -1, -1);
            chk($sformatf("v%0d_done", i), got_done, 1'b1);
            chk($sformatf("v%0d_reads", i), n_reads, vecs[i].reads);
            chk($sformatf("v%0d_bits", i), done_bits, vecs[i].bits);
            chk($sformatf("v%0d_error", i), done_err, vecs[i].err);
            chk($sformatf("v%0d_busy_done", i), done_busy, 1'b1);
            chk($sformatf("v%0d_busy_after", i), after_busy, 1'b0);
            if (vecs[i].err) chk($sformatf("v%0d_timeout_gap", i), tmo_gap, 16);
        end

        run_decode(M_ECHO, 4'd2, FRAME, -1, -1);
        chk("frame_sys_h0", rd_sys[0], FRAME);
        chk("frame_sys_h1", rd_sys[1], FRAME_INT);
        chk("frame_enc_h0", rd_enc[0], ENC1);
        chk("frame_enc_h1", rd_enc[1], ENC2);
        chk("frame_ext_r0", rd_ext[0], '0);
        chk("frame_ext_r1", rd_ext[1], pack10(pat));
        chk("frame_ext_r2", rd_ext[2], '0);
        chk("frame_ext_r3", rd_ext[3], pack10(pat));
        chk("frame_bits", done_bits, 5'b01101);

        run_decode(M_SCRIPT, 4'd3, 28'h8888888, -1, -1);
        chk("sat_reads", n_reads, 6);
        chk("sat_ext_r1", rd_ext[1], fill10(-248));
        chk("sat_ext_r2", rd_ext[2], fill10(511));
        chk("sat_ext_r3_neg", rd_ext[3], fill10(-511));
        chk("sat_ext_r4_pos", rd_ext[4], fill10(511));
        chk("sat_ext_r5_neg", rd_ext[5], fill10(-511));
        chk("sat_bits", done_bits, 5'b11111);

        run_decode(M_ECHO, 4'd1, FRAME, 4, -1);
        chk("start_in_wait_reads", n_reads, 2);
        chk("start_in_wait_bits", done_bits, 5'b01101);
        chk("start_in_wait_idle", busy_o, 1'b0);

        siso_llr_i = '1;
        siso_finish_i = 1'b1;
        @(negedge clk);
        siso_finish_i = 1'b0;
        @(negedge clk);
        chk("finish_in_idle",
            {busy_o, done_o, siso_read_en_o, bits_o, error_o, siso_sys_o, siso_enc_o, siso_ext_o},
            {3'b000, 5'b01101, 1'b0, FRAME_INT, ENC2, pack10(pat)});

        run_decode(M_ECHO, 4'd2, FRAME, -1, 2);
        repeat (2) @(negedge clk);
        chk("reset_no_done", {busy_o, done_o}, 2'b00);
        run_decode(M_ECHO, 4'd1, FRAME, -1, -1);
        chk("post_reset_done", got_done, 1'b1);
        chk("post_reset_reads", n_reads, 2);
        chk("post_reset_bits", done_bits, 5'b01101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
